// File: rtl/maxnet_pkg.sv
// Shared types and constants for the MaxNet operand store and its helpers.
package maxnet_pkg;

  localparam int FP_W = 32;

  // Weight constants: unit diagonal and the -0.2 lateral inhibition term.
  localparam logic [FP_W-1:0] FP_ONE     = 32'h3f800000;
  localparam logic [FP_W-1:0] FP_NEG_EPS = 32'hbe4ccccd;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_WB = 2'd2,
    SWAP    = 2'd3
  } state_t;

  // True for a strictly positive, non-zero float (sign clear, magnitude set).
  // Negative zero and all negative values are reported as inactive.
  function automatic logic fp_pos_nonzero(input logic [FP_W-1:0] v);
    return (v[FP_W-1] == 1'b0) && (v[FP_W-2:0] != '0);
  endfunction

endpackage

// File: rtl/maxnet_wrow_gen.sv
// Combinational weight-row generator: row k of the MaxNet weight matrix,
// built on the fly instead of storing N*N words.
module maxnet_wrow_gen #(
  parameter int               N          = 4,
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] FP_ONE     = maxnet_pkg::FP_ONE,
  parameter logic [WIDTH-1:0] FP_NEG_EPS = maxnet_pkg::FP_NEG_EPS,
  localparam int              IW         = $clog2(N)
) (
  input  logic [IW-1:0]      k,
  output logic [N*WIDTH-1:0] w_row
);

  // Lane j carries the self-excitation weight on the diagonal, inhibition elsewhere.
  always_comb begin
    w_row = '0;
    for (int j = 0; j < N; j++) begin
      w_row[j*WIDTH +: WIDTH] = (IW'(j) == k) ? FP_ONE : FP_NEG_EPS;
    end
  end

endmodule

// File: rtl/maxnet_bank_mem.sv
// Double-buffered activation store for the MaxNet iteration datapath.
// The active bank feeds x_vec; write-backs land in the shadow bank, which
// becomes active only when every lane has been written in the current sweep.
// Initial contents are written through the load port while idle.
module maxnet_bank_mem #(
  parameter int               N          = 4,
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] FP_ONE     = maxnet_pkg::FP_ONE,
  parameter logic [WIDTH-1:0] FP_NEG_EPS = maxnet_pkg::FP_NEG_EPS,
  parameter                   FILENAME_X = "trunk/sim/file/input.dat",
  localparam int              IW         = $clog2(N),
  localparam int              CW         = $clog2(N+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [IW-1:0]      load_idx,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               start,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [IW-1:0]      row_idx,
  output logic [N*WIDTH-1:0] w_row,
  output logic [N*WIDTH-1:0] x_vec,
  input  logic               wb_en,
  input  logic [IW-1:0]      wb_idx,
  input  logic [WIDTH-1:0]   wb_data,
  output logic               busy,
  output logic               iter_done,
  output logic [CW-1:0]      active_cnt,
  output logic               single_left
);

  import maxnet_pkg::*;

  logic [WIDTH-1:0] bank0 [N];
  logic [WIDTH-1:0] bank1 [N];

  state_t           state;
  logic [IW-1:0]    k;
  logic [N-1:0]     mask;
  logic [N-1:0]     mask_nxt;
  logic [N-1:0]     wb_onehot;
  logic             bank_sel;
  logic             wb_acc;
  logic             ld_acc;
  logic             row_fire;
  logic             last_row;
  logic [WIDTH-1:0] lane;

  assign row_idx = k;

  maxnet_wrow_gen #(
    .N          (N),
    .WIDTH      (WIDTH),
    .FP_ONE     (FP_ONE),
    .FP_NEG_EPS (FP_NEG_EPS)
  ) u_wrow (
    .k     (k),
    .w_row (w_row)
  );

  // Qualify loads and write-backs, and fold this cycle's write-back into the mask
  // so the last row handshake can swap without waiting an extra cycle.
  always_comb begin
    ld_acc    = (state == IDLE) && load_en && (int'(load_idx) < N);
    wb_acc    = !rst && ((state == ISSUE) || (state == WAIT_WB)) && wb_en &&
                (int'(wb_idx) < N);
    wb_onehot = '0;
    if (wb_acc) wb_onehot[wb_idx] = 1'b1;
    mask_nxt  = mask | wb_onehot;
    row_fire  = row_valid && row_ready;
    last_row  = (k == IW'(N-1));
  end

  // Storage: loads write both banks, write-backs write only the shadow bank.
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      bank0[load_idx] <= load_data;
      bank1[load_idx] <= load_data;
    end else if (wb_acc) begin
      if (bank_sel) bank0[wb_idx] <= wb_data;
      else          bank1[wb_idx] <= wb_data;
    end
  end

  // Sweep sequencer with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      mask      <= '0;
      bank_sel  <= 1'b0;
      row_valid <= 1'b0;
      busy      <= 1'b0;
      iter_done <= 1'b0;
    end else begin
      iter_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            k         <= '0;
            mask      <= '0;
            row_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          mask <= mask_nxt;
          if (row_fire) begin
            if (!last_row) begin
              k <= k + IW'(1);
            end else begin
              row_valid <= 1'b0;
              if (&mask_nxt) begin
                state     <= SWAP;
                iter_done <= 1'b1;
              end else begin
                state <= WAIT_WB;
              end
            end
          end
        end
        WAIT_WB: begin
          mask <= mask_nxt;
          if (&mask_nxt) begin
            state     <= SWAP;
            iter_done <= 1'b1;
          end
        end
        SWAP: begin
          bank_sel <= ~bank_sel;
          state    <= IDLE;
          busy     <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          row_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Active-bank view and count of lanes still holding a positive activation.
  always_comb begin
    x_vec      = '0;
    active_cnt = '0;
    lane       = '0;
    for (int j = 0; j < N; j++) begin
      lane = bank_sel ? bank1[j] : bank0[j];
      x_vec[j*WIDTH +: WIDTH] = lane;
      if (fp_pos_nonzero(lane)) active_cnt = active_cnt + CW'(1);
    end
    single_left = (active_cnt == CW'(1));
  end

endmodule

// File: tb/tb_maxnet_bank_mem.sv
// Scoreboard bench for maxnet_bank_mem: stimulus pushes expected rows and
// expected post-swap vectors; a negedge monitor pops and compares them.
module tb_maxnet_bank_mem;

  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int IW    = 2;
  localparam int CW    = 3;
  localparam int VW    = N*WIDTH;
  localparam logic [31:0] ONE = 32'h3f800000;
  localparam logic [31:0] NEG = 32'hbe4ccccd;

  typedef logic [VW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [IW-1:0] load_idx;
  logic [31:0]   load_data;
  logic          start;
  logic          row_valid;
  logic          row_ready;
  logic [IW-1:0] row_idx;
  vec_t          w_row;
  vec_t          x_vec;
  logic          wb_en;
  logic [IW-1:0] wb_idx;
  logic [31:0]   wb_data;
  logic          busy;
  logic          iter_done;
  logic [CW-1:0] active_cnt;
  logic          single_left;

  maxnet_bank_mem #(.N(N), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .start(start),
    .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx), .w_row(w_row),
    .x_vec(x_vec),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .busy(busy), .iter_done(iter_done), .active_cnt(active_cnt), .single_left(single_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: two banks of activations plus which one is visible.
  logic [31:0] mb [2][N];
  bit          msel;
  logic [31:0] wbvals [N];
  logic [31:0] img [N] = '{32'h3f800000, 32'h3f000000, 32'h3e800000, 32'h00000000};

  int   exp_rows [$];
  vec_t exp_swaps [$];
  bit   pending = 1'b0;
  vec_t pend_vec;

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %0s", name);
  endtask

  function automatic vec_t row_ref(input int kk);
    vec_t v;
    for (int j = 0; j < N; j++) v[j*WIDTH +: WIDTH] = (j == kk) ? ONE : NEG;
    return v;
  endfunction

  function automatic vec_t pack_bank(input bit s);
    vec_t v;
    for (int j = 0; j < N; j++) v[j*WIDTH +: WIDTH] = mb[s][j];
    return v;
  endfunction

  function automatic int count_pos(input vec_t v);
    int c;
    logic [31:0] w;
    c = 0;
    for (int j = 0; j < N; j++) begin
      w = v[j*WIDTH +: WIDTH];
      if (w[31] == 1'b0 && w[30:0] != 31'd0) c++;
    end
    return c;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return 32'h00000000;
      1:       return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_static(input string tag);
    vec_t v;
    v = pack_bank(msel);
    check({tag, "_x_vec"}, x_vec, v);
    check({tag, "_active_cnt"}, VW'(active_cnt), VW'(count_pos(v)));
    check({tag, "_single_left"}, VW'(single_left), VW'(count_pos(v) == 1));
  endtask

  // Monitor: pops expected rows on each handshake, and expected vectors on iter_done.
  always @(negedge clk) begin : mon
    int e;
    if (!rst) begin
      if (pending) begin
        check("x_vec_after_swap", x_vec, pend_vec);
        check("active_cnt_after_swap", VW'(active_cnt), VW'(count_pos(pend_vec)));
        check("single_left_after_swap", VW'(single_left), VW'(count_pos(pend_vec) == 1));
        pending = 1'b0;
      end
      if (row_valid && row_ready) begin
        if (exp_rows.size() == 0) begin
          fail_now("unexpected_row_handshake");
        end else begin
          e = exp_rows.pop_front();
          check("row_idx", VW'(row_idx), VW'(e));
          check("w_row", w_row, row_ref(e));
        end
      end
      if (iter_done) begin
        if (exp_swaps.size() == 0) begin
          fail_now("unexpected_iter_done");
        end else begin
          pend_vec = exp_swaps.pop_front();
          pending  = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; load_en = 1'b0; wb_en = 1'b0; row_ready = 1'b0;
    exp_rows.delete();
    exp_swaps.delete();
    pending = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    msel = 1'b0;
  endtask

  // One sweep. rdy_mode: 0 continuous, 1 pattern 1,0,0,..., 2 random.
  // wb_late: write-backs only after all rows, in reverse lane order.
  task automatic do_sweep(input int rdy_mode, input bit wb_late, input bit do_load,
                          input logic [IW-1:0] lidx, input logic [31:0] ldata);
    int   hs, wbn, cyc;
    bit   sw, fire;
    time  t0;
    vec_t ev;
    hs = 0; wbn = 0; cyc = 0; sw = 1'b0;
    start = 1'b1;
    if (do_load) begin
      load_en = 1'b1; load_idx = lidx; load_data = ldata;
      mb[0][lidx] = ldata;
      mb[1][lidx] = ldata;
    end
    for (int j = 0; j < N; j++) begin
      exp_rows.push_back(j);
      ev[j*WIDTH +: WIDTH] = wbvals[j];
    end
    exp_swaps.push_back(ev);
    t0 = $time;
    @(posedge clk);
    #1;
    start = 1'b0; load_en = 1'b0;
    while (!sw && cyc < 300) begin
      case (rdy_mode)
        0:       row_ready = 1'b1;
        1:       row_ready = (cyc % 3 == 0);
        default: row_ready = 1'($urandom_range(0, 1));
      endcase
      start     = (cyc == 1);
      load_en   = (cyc == 1);
      load_idx  = lidx;
      load_data = 32'hdeadbeef;
      if (cyc == 2) check_static("mid_sweep");
      check("row_valid", VW'(row_valid), VW'(hs < N));
      if (hs < N) check("row_idx_hold", VW'(row_idx), VW'(hs));
      wb_en = 1'b0;
      if (!wb_late && hs < N && row_ready) begin
        wb_en = 1'b1; wb_idx = IW'(hs); wb_data = wbvals[hs];
      end
      if (wb_late && hs == N && wbn < N) begin
        wb_en = 1'b1; wb_idx = IW'(N-1-wbn); wb_data = wbvals[N-1-wbn];
      end
      fire = (hs < N) && row_ready;
      @(posedge clk);
      #1;
      if (fire) hs++;
      if (wb_en) wbn++;
      cyc++;
      if (iter_done) begin
        sw = 1'b1;
        check("wb_count_at_swap", VW'(wbn), VW'(N));
        check("rows_at_swap", VW'(hs), VW'(N));
        if (rdy_mode == 0 && !wb_late)
          check("start_to_iter_done", VW'(int'(($time - t0) / 10)), VW'(N+1));
      end
    end
    wb_en = 1'b0; row_ready = 1'b0; start = 1'b0; load_en = 1'b0;
    if (!sw) begin
      fail_now("iter_done_timeout");
    end else begin
      for (int j = 0; j < N; j++) mb[!msel][j] = wbvals[j];
      msel = !msel;
    end
    @(posedge clk);
    #1;
    check("iter_done_one_cycle", VW'(iter_done), VW'(0));
    check("busy_after_swap", VW'(busy), VW'(0));
    check_static("post_swap");
  endtask

  // Sweep aborted by reset in WAIT_WB after two write-backs.
  task automatic do_abort();
    for (int j = 0; j < N; j++) exp_rows.push_back(j);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      row_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    row_ready = 1'b0;
    check("abort_row_valid_low", VW'(row_valid), VW'(0));
    for (int i = 0; i < 2; i++) begin
      wb_en = 1'b1; wb_idx = IW'(i); wb_data = 32'h3f400000;
      mb[!msel][i] = 32'h3f400000;
      @(posedge clk);
      #1;
    end
    wb_en = 1'b0;
    check("abort_busy_in_wait", VW'(busy), VW'(1));
    check("abort_no_swap", VW'(iter_done), VW'(0));
    do_reset();
    check("abort_busy", VW'(busy), VW'(0));
    check("abort_row_idx", VW'(row_idx), VW'(0));
    check("abort_iter_done", VW'(iter_done), VW'(0));
    check_static("after_abort");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load_en = 1'b0; load_idx = '0; load_data = '0; start = 1'b0;
    row_ready = 1'b0; wb_en = 1'b0; wb_idx = '0; wb_data = '0; msel = 1'b0;
    do_reset();
    check("reset_busy", VW'(busy), VW'(0));
    check("reset_row_valid", VW'(row_valid), VW'(0));
    check("reset_row_idx", VW'(row_idx), VW'(0));
    check("reset_iter_done", VW'(iter_done), VW'(0));
    check("reset_w_row", w_row, row_ref(0));

    // Image load through the idle load port.
    for (int j = 0; j < N; j++) begin
      load_en = 1'b1; load_idx = IW'(j); load_data = img[j];
      mb[0][j] = img[j];
      mb[1][j] = img[j];
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;
    check_static("image");
    check("image_cnt_3", VW'(active_cnt), VW'(3));
    check("image_single_0", VW'(single_left), VW'(0));

    // Continuous ready, write-back alongside each row: minimum latency.
    for (int j = 0; j < N; j++) wbvals[j] = rand_word();
    do_sweep(0, 1'b0, 1'b0, '0, '0);

    // Stalling ready, late write-backs; one survivor remains.
    wbvals = '{32'h3f000000, 32'h0, 32'h0, 32'h0};
    do_sweep(1, 1'b1, 1'b0, '0, '0);
    check("one_left_cnt", VW'(active_cnt), VW'(1));
    check("one_left_single", VW'(single_left), VW'(1));

    wbvals = '{32'h0, 32'h0, 32'h0, 32'h0};
    do_sweep(2, 1'b0, 1'b0, '0, '0);
    check("none_left_cnt", VW'(active_cnt), VW'(0));

    for (int j = 0; j < N; j++) wbvals[j] = rand_word();
    do_sweep(2, 1'b1, 1'b0, '0, '0);

    do_abort();

    // Stale write-backs from the aborted sweep must not complete this one.
    for (int j = 0; j < N; j++) wbvals[j] = rand_word();
    do_sweep(2, 1'b1, 1'b0, '0, '0);

    // Load in the same cycle as start is visible to the sweep.
    for (int j = 0; j < N; j++) wbvals[j] = rand_word();
    do_sweep(0, 1'b0, 1'b1, IW'(1), 32'h40000000);

    for (int s = 0; s < 6; s++) begin
      for (int j = 0; j < N; j++) wbvals[j] = rand_word();
      do_sweep($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               IW'($urandom_range(0, N-1)), $urandom);
    end

    repeat (2) @(posedge clk);
    #1;
    check("rows_queue_drained", VW'(exp_rows.size()), VW'(0));
    check("swaps_queue_drained", VW'(exp_swaps.size()), VW'(0));
    check("no_pending_vec", VW'(pending), VW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
